tick_serial_tx: RTL and testbench
=================================

# tick_serial_tx

Tick-paced serial transmitter that consumes the single-cycle strobe produced by the clock-divider stage. Parallel words enter through a valid/ready handshake into a small FIFO. Each word is shifted out LSB-first as an asynchronous-serial frame: start bit, DATA_W data bits, then STOP_BITS stop bits. Every bit lasts exactly one strobe period.

## Interface
- DATA_W, 8, data bits per frame (1..16)
- FIFO_DEPTH, 4, input FIFO entries (power of two, ≥2)
- STOP_BITS, 1, stop bits per frame (1 or 2)
- i_clk  input  1  system clock; all logic on its rising edge
- i_reset  input  1  asynchronous, active-high reset
- i_tick  input  1  bit-rate strobe, one i_clk cycle wide (divider output)
- i_data  input  DATA_W  word to transmit
- i_valid  input  1  i_data valid
- o_ready  output  1  FIFO can accept; transfer when i_valid && o_ready
- o_tx  output  1  serial line, registered, idle high
- o_busy  output  1  frame in progress or FIFO non-empty

## Operation
- FIFO
  - Push on i_valid && o_ready.
  - o_ready = (count < FIFO_DEPTH) && !i_reset.
  - Pop is performed only by the FSM, and only from registered count > 0. A word pushed in cycle N is poppable from cycle N+1 onward.
  - Push and pop in the same cycle leave count unchanged. Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP. It advances only on cycles with i_tick=1; i_tick has no effect in any other case.
  - IDLE, tick, FIFO non-empty: pop into shifter, o_tx<=0, go to START.
  - IDLE, tick, FIFO empty: stay in IDLE, o_tx stays 1.
  - START, tick: o_tx<=shifter[0], shift right, bit_cnt<=1, go to DATA.
  - DATA, tick, bit_cnt<DATA_W: o_tx<=shifter[0], shift, bit_cnt++.
  - DATA, tick, bit_cnt==DATA_W: o_tx<=1, stop_cnt<=1, go to STOP.
  - STOP, tick, stop_cnt<STOP_BITS: stop_cnt++.
  - STOP, tick, stop_cnt==STOP_BITS, FIFO non-empty: pop, o_tx<=0, go to START (back-to-back frames, no extra idle bit).
  - STOP, tick, stop_cnt==STOP_BITS, FIFO empty: go to IDLE, o_tx stays 1.
- o_busy = (state != IDLE) || (count != 0). It is registered-state derived, with no combinational path from i_valid.
- Words are transmitted in push order. No word is dropped or duplicated.

## Timing
- Reset (asynchronous, any state, mid-frame included):
  - State=IDLE, o_tx=1, FIFO count/pointers=0, bit_cnt=0, stop_cnt=0, o_busy=0, o_ready=0 while asserted.
  - A partially sent frame is abandoned. The line returns high immediately.
- o_tx changes only in the cycle after a tick cycle. Each line level therefore holds for exactly one tick period (DIVIDER+1 i_clk cycles at the divider's rate).
- Latency:
  - Word accepted in cycle N, FSM in IDLE: start bit appears the cycle after the first tick in a cycle ≥ N+1.
  - Tick in cycle N itself: that tick is not used. The frame starts at the next tick.
- Frame length: exactly 1+DATA_W+STOP_BITS tick periods.
- FIFO full: o_ready=0. A pop frees a slot and o_ready rises the following cycle.
- i_tick asserted on consecutive cycles: each asserted cycle is a separate tick. The bench must not rely on this; the divider never produces it.

## Test plan
- Reset mid-DATA (tick every 4 cycles, 0xA5 half sent) -> o_tx=1 and o_busy=0 in the same cycle. The next word sends cleanly as a full frame.
- Single word 0xA5, DATA_W=8, STOP_BITS=1, tick every 4 cycles -> o_tx sequence per tick is 0,1,0,1,0,0,1,0,1,1. The frame lasts 40 cycles and o_busy falls after the stop bit.
- Push 0x01,0x02,0x03 back-to-back -> three contiguous frames with no idle bit between them. o_busy stays high for 30 tick periods.
- Push 6 words with FIFO_DEPTH=4 while i_valid is held high -> o_ready drops after the FIFO fills and re-asserts after each pop. All 6 words are transmitted in order.
- STOP_BITS=2, word 0xFF -> low start bit, 8 high bits, then 2 high stop bits. The next start bit appears exactly 11 ticks after the first.
- Push exactly on a tick cycle while IDLE -> that tick is ignored. The start bit appears after the next tick.

Source files
------------

// File: rtl/tick_serial_tx_if.sv
// rtl/tick_serial_tx_if.sv - valid/ready word handshake feeding tick_serial_tx
interface tick_serial_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/tick_serial_tx.sv
// rtl/tick_serial_tx.sv - tick-paced LSB-first async serial transmitter with input FIFO
module tick_serial_tx #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_tick,
  tick_serial_tx_if.slave in_if,
  output logic            o_tx,
  output logic            o_busy
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int BW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              push, pop, fifo_empty;

  state_t            state, state_n;
  logic [DATA_W-1:0] shifter, shifter_n;
  logic [BW-1:0]     bit_cnt, bit_cnt_n;
  logic [1:0]        stop_cnt, stop_cnt_n;
  logic              tx, tx_n;

  assign in_if.ready = (count < CW'(FIFO_DEPTH)) && !i_reset;
  assign push        = in_if.valid && in_if.ready;
  // Pops only see the registered count, so a word pushed this cycle waits a cycle.
  assign fifo_empty  = (count == '0);

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= in_if.data;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= IDLE;
      shifter  <= '0;
      bit_cnt  <= '0;
      stop_cnt <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_n;
      shifter  <= shifter_n;
      bit_cnt  <= bit_cnt_n;
      stop_cnt <= stop_cnt_n;
      tx       <= tx_n;
    end
  end

  always_comb begin
    state_n    = state;
    shifter_n  = shifter;
    bit_cnt_n  = bit_cnt;
    stop_cnt_n = stop_cnt;
    tx_n       = tx;
    pop        = 1'b0;
    if (i_tick) begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            shifter_n = mem[rd_ptr];
            tx_n      = 1'b0;
            state_n   = START;
          end
        end
        START: begin
          tx_n      = shifter[0];
          shifter_n = shifter >> 1;
          bit_cnt_n = BW'(1);
          state_n   = DATA;
        end
        DATA: begin
          if (bit_cnt < BW'(DATA_W)) begin
            tx_n      = shifter[0];
            shifter_n = shifter >> 1;
            bit_cnt_n = bit_cnt + BW'(1);
          end else begin
            tx_n       = 1'b1;
            stop_cnt_n = 2'd1;
            state_n    = STOP;
          end
        end
        STOP: begin
          if (stop_cnt < 2'(STOP_BITS)) begin
            stop_cnt_n = stop_cnt + 2'd1;
          end else if (!fifo_empty) begin
            // Chain straight into the next start bit, no idle period between frames.
            pop       = 1'b1;
            shifter_n = mem[rd_ptr];
            tx_n      = 1'b0;
            state_n   = START;
          end else begin
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign o_tx   = tx;
  assign o_busy = (state != IDLE) || !fifo_empty;
endmodule

// File: tb/tb_tick_serial_tx.sv
// tb/tb_tick_serial_tx.sv - scoreboard bench for tick_serial_tx
`timescale 1ns/1ps
module tb_tick_serial_tx;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic tx0, busy0, tx1, busy1;

  int checks = 0;
  int failures = 0;

  tick_serial_tx_if #(.DATA_W(DW)) if0 ();
  tick_serial_tx_if #(.DATA_W(DW)) if1 ();

  tick_serial_tx #(.DATA_W(DW), .FIFO_DEPTH(4), .STOP_BITS(1)) dut (
    .i_clk(clk), .i_reset(rst), .i_tick(tick), .in_if(if0), .o_tx(tx0), .o_busy(busy0)
  );

  tick_serial_tx #(.DATA_W(DW), .FIFO_DEPTH(4), .STOP_BITS(2)) dut2 (
    .i_clk(clk), .i_reset(rst), .i_tick(tick), .in_if(if1), .o_tx(tx1), .o_busy(busy1)
  );

  always #5 clk = ~clk;

  // Divider model: one-cycle strobe every 4 clocks.
  int phase = 0;
  initial forever begin
    @(posedge clk);
    #1;
    phase = (phase + 1) % 4;
    tick  = (phase == 0);
  end

  int cyc = 0;
  int tick_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tick) tick_cnt <= tick_cnt + 1;
  end

  logic [DW-1:0] exp0[$];
  logic [DW-1:0] exp1[$];
  int st_tick0[$], st_cyc0[$], fall_cyc0[$], st_tick1[$];
  int ready_low = 0;

  int md[2], mi[2], ms[2];
  logic [DW-1:0] mw[2];
  logic last_tx[2], last_busy[2];
  logic tick_prev = 1'b0;
  logic rst_prev = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic mon(input int id, input logic txv, input logic busyv, input int sb);
    logic [DW-1:0] e;
    if (rst) begin
      md[id] = 0;
    end else if (tick_prev) begin
      case (md[id])
        0: if (txv == 1'b0) begin
          md[id] = 1;
          mi[id] = 0;
          if (id == 0) begin
            st_tick0.push_back(tick_cnt);
            st_cyc0.push_back(cyc);
          end else begin
            st_tick1.push_back(tick_cnt);
          end
        end
        1: begin
          mw[id][mi[id]] = txv;
          mi[id]++;
          if (mi[id] == DW) begin
            md[id] = 2;
            ms[id] = 0;
          end
        end
        default: begin
          chk($sformatf("stop_bit_dut%0d", id), 32'(txv), 32'd1);
          ms[id]++;
          if (ms[id] == sb) begin
            md[id] = 0;
            if ((id == 0 ? exp0.size() : exp1.size()) == 0) begin
              chk($sformatf("unexpected_frame_dut%0d", id), 32'(mw[id]), 32'hFFFF_FFFF);
            end else begin
              e = (id == 0) ? exp0.pop_front() : exp1.pop_front();
              chk($sformatf("frame_data_dut%0d", id), 32'(mw[id]), 32'(e));
            end
          end
        end
      endcase
    end else if (!rst_prev) begin
      chk($sformatf("line_hold_dut%0d", id), 32'(txv), 32'(last_tx[id]));
    end
    if (id == 0 && !rst && !rst_prev && last_busy[id] && !busyv) fall_cyc0.push_back(cyc);
    last_tx[id]   = txv;
    last_busy[id] = busyv;
  endtask

  always @(negedge clk) begin
    mon(0, tx0, busy0, 1);
    mon(1, tx1, busy1, 2);
    tick_prev = tick;
    rst_prev  = rst;
  end

  task automatic sync();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int id, input logic [DW-1:0] d, input bit expect_it);
    bit done = 1'b0;
    int n = 0;
    if (id == 0) begin if0.data = d; if0.valid = 1'b1; end
    else         begin if1.data = d; if1.valid = 1'b1; end
    while (!done && n < 400) begin
      @(negedge clk);
      if ((id == 0) ? if0.ready : if1.ready) done = 1'b1;
      else ready_low++;
      @(posedge clk);
      n++;
    end
    #2;
    if (!done) chk("push_timeout", 32'd0, 32'd1);
    else if (expect_it) begin
      if (id == 0) exp0.push_back(d);
      else         exp1.push_back(d);
    end
    if (id == 0) if0.valid = 1'b0;
    else         if1.valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (n < 2000 && (busy0 || busy1 || md[0] != 0 || md[1] != 0)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("idle_timeout", 32'd0, 32'd1);
    repeat (8) @(posedge clk);
    #2;
  endtask

  task automatic clear_q();
    st_tick0.delete();
    st_cyc0.delete();
    fall_cyc0.delete();
    st_tick1.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int n;
    logic [DW-1:0] six[6];
    if0.valid = 1'b0; if0.data = '0;
    if1.valid = 1'b0; if1.data = '0;
    for (int i = 0; i < 2; i++) begin
      md[i] = 0; mi[i] = 0; ms[i] = 0; mw[i] = '0; last_tx[i] = 1'b1; last_busy[i] = 1'b0;
    end
    six[0] = 8'h11; six[1] = 8'h22; six[2] = 8'h33;
    six[3] = 8'h44; six[4] = 8'h55; six[5] = 8'h66;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_tx0", 32'(tx0), 32'd1);
    chk("reset_busy0", 32'(busy0), 32'd0);
    chk("reset_ready0", 32'(if0.ready), 32'd0);
    chk("reset_tx1", 32'(tx1), 32'd1);
    chk("reset_ready1", 32'(if1.ready), 32'd0);
    sync();
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(if0.ready), 32'd1);

    // Single 0xA5: 40-cycle frame, busy falls after the stop bit.
    clear_q();
    sync();
    push(0, 8'hA5, 1'b1);
    wait_idle();
    chk("a5_starts", 32'(st_cyc0.size()), 32'd1);
    chk("a5_falls", 32'(fall_cyc0.size()), 32'd1);
    if (st_cyc0.size() == 1 && fall_cyc0.size() == 1)
      chk("a5_frame_cycles", 32'(fall_cyc0[0] - st_cyc0[0]), 32'd40);

    // Three back-to-back frames, no idle bit, busy high across all 30 ticks.
    clear_q();
    sync();
    push(0, 8'h01, 1'b1);
    push(0, 8'h02, 1'b1);
    push(0, 8'h03, 1'b1);
    wait_idle();
    chk("b2b_starts", 32'(st_tick0.size()), 32'd3);
    chk("b2b_falls", 32'(fall_cyc0.size()), 32'd1);
    if (st_tick0.size() == 3) begin
      chk("b2b_gap1", 32'(st_tick0[1] - st_tick0[0]), 32'd10);
      chk("b2b_gap2", 32'(st_tick0[2] - st_tick0[1]), 32'd10);
    end
    if (st_cyc0.size() == 3 && fall_cyc0.size() == 1)
      chk("b2b_busy_cycles", 32'(fall_cyc0[0] - st_cyc0[0]), 32'd120);

    // Six words with valid held: FIFO fills, ready drops, order preserved.
    clear_q();
    ready_low = 0;
    sync();
    for (int i = 0; i < 6; i++) push(0, six[i], 1'b1);
    chk("full_ready_dropped", 32'(ready_low > 0), 32'd1);
    wait_idle();
    chk("six_starts", 32'(st_tick0.size()), 32'd6);

    // Reset mid-DATA abandons the frame; line high and busy low at once.
    clear_q();
    sync();
    push(0, 8'hA5, 1'b0);
    n = 0;
    while (n < 400 && !(md[0] == 1 && mi[0] >= 4)) begin
      @(negedge clk);
      n++;
    end
    chk("mid_data_reached", 32'(n < 400), 32'd1);
    sync();
    rst = 1'b1;
    #1;
    chk("midrst_tx", 32'(tx0), 32'd1);
    chk("midrst_busy", 32'(busy0), 32'd0);
    chk("midrst_ready", 32'(if0.ready), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    clear_q();
    push(0, 8'h3C, 1'b1);
    wait_idle();
    chk("post_reset_starts", 32'(st_tick0.size()), 32'd1);

    // Two stop bits: next start 11 ticks after the first.
    clear_q();
    sync();
    push(1, 8'hFF, 1'b1);
    push(1, 8'h00, 1'b1);
    wait_idle();
    chk("sb2_starts", 32'(st_tick1.size()), 32'd2);
    if (st_tick1.size() == 2)
      chk("sb2_gap", 32'(st_tick1[1] - st_tick1[0]), 32'd11);

    // Push landing on a tick cycle: that tick is ignored.
    clear_q();
    n = 0;
    sync();
    while (!tick && n < 10) begin
      sync();
      n++;
    end
    // Push takes a negedge then posedge; advance so the transfer edge carries the tick.
    n = 0;
    while (phase != 3 && n < 10) begin
      sync();
      n++;
    end
    push(0, 8'h5A, 1'b1);
    t = tick_cnt;
    wait_idle();
    chk("tick_push_starts", 32'(st_tick0.size()), 32'd1);
    if (st_tick0.size() == 1)
      chk("tick_push_start_tick", 32'(st_tick0[0]), 32'(t + 1));

    chk("exp0_drained", 32'(exp0.size()), 32'd0);
    chk("exp1_drained", 32'(exp1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
